// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out framer.
package sipo_pkg;
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-MOD bit counter; wrap flags the last bit of a frame while enabled.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int MOD   = 8,
  parameter int CNT_W = clog2(MOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= wrap ? '0 : count + CNT_W'(1);
  end
endmodule

// File: rtl/shift_sipo_framer.sv
// Serial-in/parallel-out framer: assembles WIDTH-bit words LSB- or MSB-first
// and publishes each completed word with a one-cycle valid strobe.
module shift_sipo_framer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_data_in,
  input  logic                     shift_en,
  input  logic                     lsb_first,
  input  logic                     clear,
  output logic [WIDTH-1:0]         shift_reg_out,
  output logic [WIDTH-1:0]         parallel_data_out,
  output logic                     data_valid,
  output logic [clog2(WIDTH)-1:0]  bit_count,
  output logic                     busy
);
  localparam int CNT_W = clog2(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("shift_sipo_framer: WIDTH out of range");
    end
  endgenerate

  logic             mode;
  logic             eff_mode;
  logic             wrap;
  logic [WIDTH-1:0] shifted;

  sipo_bit_counter #(.MOD(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .clr   (clear),
    .count (bit_count),
    .wrap  (wrap)
  );

  // At frame start the incoming mode applies to bit 0 already.
  assign eff_mode = (bit_count == '0) ? lsb_first : mode;
  assign shifted  = (eff_mode == DIR_LSB_FIRST)
                  ? {serial_data_in, shift_reg_out[WIDTH-1:1]}
                  : {shift_reg_out[WIDTH-2:0], serial_data_in};
  assign busy     = (bit_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg_out     <= '0;
      parallel_data_out <= '0;
      data_valid        <= 1'b0;
      mode              <= DIR_MSB_FIRST;
    end else if (clear) begin
      shift_reg_out <= '0;
      data_valid    <= 1'b0;
    end else if (shift_en) begin
      shift_reg_out <= shifted;
      if (bit_count == '0) mode <= lsb_first;
      if (wrap) parallel_data_out <= shifted;
      data_valid <= wrap;
    end else begin
      data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_sipo_framer.sv
// Directed bench for shift_sipo_framer at WIDTH=4 and WIDTH=8 with a
// word-assembly reference model checked every cycle.
module tb_shift_sipo_framer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       d4, en4, l4, c4;
  logic [3:0] sr4, po4;
  logic       dv4, bz4;
  logic [1:0] bc4;

  logic       d8, en8, l8, c8;
  logic [7:0] sr8, po8;
  logic       dv8, bz8;
  logic [2:0] bc8;

  shift_sipo_framer #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .serial_data_in(d4), .shift_en(en4),
    .lsb_first(l4), .clear(c4), .shift_reg_out(sr4), .parallel_data_out(po4),
    .data_valid(dv4), .bit_count(bc4), .busy(bz4)
  );

  shift_sipo_framer #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .serial_data_in(d8), .shift_en(en8),
    .lsb_first(l8), .clear(c8), .shift_reg_out(sr8), .parallel_data_out(po8),
    .data_valid(dv8), .bit_count(bc8), .busy(bz8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit i of a frame lands at position i (LSB-first) or
  // WIDTH-1-i (MSB-first); the live register is a plain shift.
  typedef struct {
    logic [63:0] sreg;
    logic [63:0] word;
    logic [63:0] pout;
    int          cnt;
    bit          mode;
    bit          dv;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.sreg = '0; m.word = '0; m.pout = '0; m.cnt = 0; m.mode = 1'b0; m.dv = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int w, input bit clr,
                                 input bit en, input bit din, input bit lsb);
    mdl_t n;
    logic [63:0] mask;
    int pos;
    n = m;
    n.dv = 1'b0;
    mask = (64'd1 << w) - 64'd1;
    if (clr) begin
      n.sreg = '0; n.word = '0; n.cnt = 0;
    end else if (en) begin
      if (m.cnt == 0) begin n.mode = lsb; n.word = '0; end
      pos = n.mode ? m.cnt : (w - 1 - m.cnt);
      n.word[pos] = din;
      if (n.mode) n.sreg = (m.sreg >> 1) | (64'(din) << (w - 1));
      else        n.sreg = ((m.sreg << 1) | 64'(din)) & mask;
      if (m.cnt == w - 1) begin
        n.pout = n.word; n.dv = 1'b1; n.cnt = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    return n;
  endfunction

  mdl_t m4, m8;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m4 <= mreset();
      m8 <= mreset();
    end else begin
      m4 <= mstep(m4, 4, c4, en4, d4, l4);
      m8 <= mstep(m8, 8, c8, en8, d8, l8);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("w4_sreg", 64'(sr4), m4.sreg);
      chk("w4_pout", 64'(po4), m4.pout);
      chk("w4_dv",   64'(dv4), 64'(m4.dv));
      chk("w4_cnt",  64'(bc4), 64'(m4.cnt));
      chk("w4_busy", 64'(bz4), 64'(m4.cnt != 0));
      chk("w8_sreg", 64'(sr8), m8.sreg);
      chk("w8_pout", 64'(po8), m8.pout);
      chk("w8_dv",   64'(dv8), 64'(m8.dv));
      chk("w8_cnt",  64'(bc8), 64'(m8.cnt));
      chk("w8_busy", 64'(bz8), 64'(m8.cnt != 0));
    end
  end

  // Each drive applies one edge; on return outputs reflect that edge.
  task automatic drv4(input bit en, input bit d, input bit l, input bit c);
    en4 = en; d4 = d; l4 = l; c4 = c;
    @(negedge clk); #1;
  endtask

  task automatic drv8(input bit en, input bit d, input bit l, input bit c);
    en8 = en; d8 = d; l8 = l; c8 = c;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] b4;
    en4 = 0; d4 = 0; l4 = 0; c4 = 0;
    en8 = 0; d8 = 0; l8 = 0; c8 = 0;
    reset = 1'b1;
    #12;
    chk("rst_po8", 64'(po8), 64'h0);
    chk("rst_bc4", 64'(bc4), 64'h0);
    chk("rst_dv4", 64'(dv4), 64'h0);
    @(negedge clk); reset = 1'b0; #1;

    // 1: LSB-first 1,0,1,1 -> 1101
    b4 = 4'b1101;
    for (int i = 0; i < 4; i++) drv4(1, b4[i], 1, 0);
    chk("t1_word", 64'(po4), 64'hD);
    chk("t1_dv",   64'(dv4), 64'h1);
    chk("t1_cnt",  64'(bc4), 64'h0);
    drv4(0, 0, 1, 0);
    chk("t1_dv_off", 64'(dv4), 64'h0);

    // 2: MSB-first 1,0,1,1 -> 1011, then mode toggled mid-frame is ignored
    b4 = 4'b1011;
    for (int i = 3; i >= 0; i--) drv4(1, b4[i], 0, 0);
    chk("t2_word_a", 64'(po4), 64'hB);
    drv4(1, 0, 0, 0);
    drv4(1, 1, 0, 0);
    drv4(1, 1, 1, 0);
    drv4(1, 0, 1, 0);
    chk("t2_word_b", 64'(po4), 64'h6);
    chk("t2_dv",     64'(dv4), 64'h1);

    // 5: clear on the last bit discards the frame
    b4 = 4'b1101;
    for (int i = 0; i < 4; i++) drv4(1, b4[i], 1, 0);
    chk("t5_word", 64'(po4), 64'hD);
    drv4(1, 0, 1, 0);
    drv4(1, 0, 1, 0);
    drv4(1, 1, 1, 0);
    drv4(1, 1, 1, 1);
    chk("t5_dv",   64'(dv4), 64'h0);
    chk("t5_word2",64'(po4), 64'hD);
    chk("t5_cnt",  64'(bc4), 64'h0);
    chk("t5_sreg", 64'(sr4), 64'h0);
    drv4(0, 0, 0, 0);

    // 3: 0xA5 MSB-first with gaps
    v = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      drv8(1, v[i], 0, 0);
      chk("t3_dv_en", 64'(dv8), 64'(i == 0));
      drv8(0, 0, 0, 0);
      chk("t3_dv_gap", 64'(dv8), 64'h0);
    end
    chk("t3_word", 64'(po8), 64'hA5);

    // 4: back-to-back 0x3C then 0xC3 LSB-first
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      drv8(1, v[i], 1, 0);
      chk("t4_dv_a", 64'(dv8), 64'(i == 7));
    end
    chk("t4_word_a", 64'(po8), 64'h3C);
    v = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      drv8(1, v[i], 1, 0);
      chk("t4_dv_b", 64'(dv8), 64'(i == 7));
    end
    chk("t4_word_b", 64'(po8), 64'hC3);
    drv8(0, 0, 1, 0);

    // 6: async reset mid-frame after 5 bits
    for (int i = 0; i < 5; i++) drv8(1, 1, 0, 0);
    chk("t6_cnt5", 64'(bc8), 64'h5);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t6_sreg", 64'(sr8), 64'h0);
    chk("t6_pout", 64'(po8), 64'h0);
    chk("t6_cnt",  64'(bc8), 64'h0);
    chk("t6_busy", 64'(bz8), 64'h0);
    chk("t6_dv",   64'(dv8), 64'h0);
    #1 reset = 1'b0;
    en8 = 0;
    @(negedge clk); #1;
    v = 8'h96;
    for (int i = 7; i >= 0; i--) drv8(1, v[i], 0, 0);
    chk("t6_word", 64'(po8), 64'h96);
    chk("t6_dv2",  64'(dv8), 64'h1);
    drv8(0, 0, 0, 0);
    drv8(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
